// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits; registered serial output.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(BPS_CNT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t state, state_n;

  logic          en_d0;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift_reg, shift_n;
  logic          par_bit, par_n;
  logic          txd_n, busy_n;
  logic          start, baud_done;

  assign start     = send_en & ~en_d0;
  assign baud_done = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      en_d0     <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      uart_txd  <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      en_d0     <= send_en;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      uart_txd  <= txd_n;
      tx_busy   <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    par_n   = par_bit;
    txd_n   = uart_txd;
    busy_n  = tx_busy;
    if (state != IDLE) begin
      baud_n = baud_done ? '0 : baud_cnt + CW'(1);
    end
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = START;
          shift_n = send_data;
          par_n   = (PARITY == 1) ? ~^send_data : ^send_data;
          baud_n  = '0;
          bit_n   = '0;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          state_n = DATA;
          txd_n   = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              txd_n   = par_bit;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = shift_reg >> 1;
            txd_n   = shift_reg[1];
          end
        end
      end
      PAR: begin
        if (baud_done) begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (baud_done) begin
          if (bit_cnt == STOP_LAST) begin
            state_n = IDLE;
            bit_n   = '0;
            busy_n  = 1'b0;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, meaning the line baud rate.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits.
REQ-005 The block SHALL have port clk, input, 1 bit, the system clock; one clock domain only.
REQ-006 The block SHALL have port sys_rst, input, 1 bit, reset; synchronous to clk and active-high.
REQ-007 The block SHALL have port send_en, input, 1 bit, the transmit request; level-held by the producer and acted on at its rising edge.
REQ-008 The block SHALL have port send_data, input, 8 bits, the byte to transmit.
REQ-009 The block SHALL have port tx_busy, output, 1 bit, high while a frame is in progress.
REQ-010 The block SHALL have port uart_txd, output, 1 bit, the serial line; idle high.

Function
REQ-011 Bit period SHALL be BPS_CNT = CLK_FREQ / UART_BPS clk cycles, using integer division with truncation; the baud counter SHALL be wide enough for BPS_CNT-1.
REQ-012 send_en SHALL be registered once (en_d0); start condition = send_en & ~en_d0.
REQ-013 On the start condition in IDLE:
- send_data SHALL be latched into a shift register in the same cycle.
- tx_busy SHALL go high on the next cycle.
- uart_txd SHALL go low (start bit) on the next cycle.
REQ-014 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
- IDLE -> START on the start condition.
- START -> DATA after BPS_CNT cycles.
- DATA SHALL send 8 bits LSB first, each BPS_CNT cycles, then go to PAR if PARITY != 0, else to STOP.
- PAR SHALL last BPS_CNT cycles, then go to STOP.
- STOP SHALL hold the line high for STOP_BITS*BPS_CNT cycles, then go to IDLE.
REQ-015 Parity bit SHALL be ^data for even and ~^data for odd, computed from the latched byte.
REQ-016 tx_busy SHALL fall on the same cycle the FSM re-enters IDLE; total busy time SHALL be (1+8+P+STOP_BITS)*BPS_CNT cycles, with P = 1 when parity is enabled, else 0.
REQ-017 A start condition while tx_busy=1 SHALL be ignored and not queued; changes to send_data while busy SHALL NOT affect the frame.
REQ-018 send_en held high across frames SHALL NOT retrigger; a new frame requires send_en low for at least one cycle and then high.
REQ-019 A start condition on the cycle tx_busy falls (FSM already in IDLE) SHALL be accepted.
REQ-020 uart_txd SHALL be a registered output and SHALL be glitch-free.
REQ-021 uart_txd SHALL be high in IDLE and STOP.

Reset
REQ-022 While sys_rst=1, the outputs and internal state SHALL be:
- uart_txd = 1, tx_busy = 0, FSM = IDLE.
- baud and bit counters = 0, shift register = 0.
- en_d0 = 1.
REQ-023 Because en_d0 resets to 1, a send_en level held high through reset SHALL NOT start a frame.
REQ-024 sys_rst asserted mid-frame SHALL abort the frame, with uart_txd = 1 and tx_busy = 0 on the cycle after the sampled reset.

Verification
REQ-025 The bench SHALL cover these directed scenarios, all with defaults (BPS_CNT = 434):
- send_data=0x55, send_en 0->1: uart_txd = 0,1,0,1,0,1,0,1,0,1, each 434 cycles; tx_busy high for exactly 4340 cycles.
- PARITY=2, send_data=0x07: bits 1,1,1,0,0,0,0,0 then parity 1, then stop; busy for 4774 cycles.
- PARITY=1, STOP_BITS=2, send_data=0x00: parity bit 1; line high for 868 cycles before tx_busy falls; busy for 5208 cycles.
- Second send_en edge at cycle 2000 of a frame, with send_data changed to 0xFF: the first frame is unchanged and no second frame follows.
- send_en held high, sys_rst pulsed for 1 cycle at frame cycle 1500: uart_txd = 1 and tx_busy = 0 on the next cycle; no new frame until send_en toggles low then high.
- Back-to-back frames 0xA5 then 0x3C, each triggered by a send_en edge on the cycle tx_busy falls: two contiguous frames with no idle gap and correct bit order.
